// File: rtl/ramp_adc_pkg.sv
// Shared types and sizing helpers for the single-slope ramp ADC sequencer.
package ramp_adc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Settle counter width; never narrower than one bit so a single-cycle settle still has a counter.
    function automatic int settle_cnt_width(input int settle_cycles);
        return (settle_cycles > 1) ? $clog2(settle_cycles) : 1;
    endfunction

endpackage

// File: rtl/ramp_adc_sequencer_comp_sync.sv
// Multi-flop synchronizer that brings the asynchronous comparator into the clk domain.
module comp_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic sync_out
);

    logic [SYNC_STAGES-1:0] sync_r;

    // Shift chain; stage 0 is the only flop allowed to go metastable.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], async_in};
        end
    end

    assign sync_out = sync_r[SYNC_STAGES-1];

endmodule

// File: rtl/ramp_adc_sequencer.sv
// Single-slope ramp ADC controller: ramps dac_code, samples the synchronized comparator, hands off the result.
// Optional build macro RAMP_ADC_CONT_CONV_EN selects continuous conversion after each handshake.
module ramp_adc_sequencer
    import ramp_adc_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 16,
    parameter int SYNC_STAGES   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             comp_in,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             overflow
);

    localparam int                 CNT_W      = settle_cnt_width(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [WIDTH-1:0]   FULL_SCALE = {WIDTH{1'b1}};

    state_t             state_r;
    state_t             state_nx;
    logic [WIDTH-1:0]   code_r;
    logic [WIDTH-1:0]   code_nx;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nx;
    logic               busy_r;
    logic               valid_r;
    logic [WIDTH-1:0]   result_r;
    logic               overflow_r;
    logic               capture_s;
    logic               cap_ovf_s;
    logic               comp_s;

    comp_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_comp_sync (
        .clk     (clk),
        .reset   (reset),
        .async_in(comp_in),
        .sync_out(comp_s)
    );

    // Next-state, next-code and capture strobe decode.
    always_comb begin
        state_nx  = state_r;
        code_nx   = code_r;
        cnt_nx    = cnt_r;
        capture_s = 1'b0;
        cap_ovf_s = 1'b0;
        case (state_r)
            IDLE: begin
                code_nx = '0;
                cnt_nx  = '0;
                if (start) begin
                    state_nx = SETTLE;
                end else begin
                    state_nx = IDLE;
                end
            end
            SETTLE: begin
                if (cnt_r == CNT_LAST) begin
                    state_nx = SAMPLE;
                end else begin
                    cnt_nx = cnt_r + CNT_W'(1);
                end
            end
            SAMPLE: begin
                if (comp_s) begin
                    capture_s = 1'b1;
                    state_nx  = DONE;
                end else if (code_r == FULL_SCALE) begin
                    // Never tripped: report full scale and flag it instead of wrapping.
                    capture_s = 1'b1;
                    cap_ovf_s = 1'b1;
                    state_nx  = DONE;
                end else begin
                    code_nx  = code_r + WIDTH'(1);
                    cnt_nx   = '0;
                    state_nx = SETTLE;
                end
            end
            DONE: begin
                if (valid_r && result_ready) begin
                    code_nx = '0;
                    cnt_nx  = '0;
`ifdef RAMP_ADC_CONT_CONV_EN
                    state_nx = SETTLE;
`else
                    state_nx = IDLE;
`endif
                end else begin
                    state_nx = DONE;
                end
            end
            default: begin
                state_nx = IDLE;
                code_nx  = '0;
                cnt_nx   = '0;
            end
        endcase
    end

    // Sequencer state plus registered status flags aligned with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            code_r  <= '0;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_nx;
            code_r  <= code_nx;
            cnt_r   <= cnt_nx;
            busy_r  <= (state_nx != IDLE);
            valid_r <= (state_nx == DONE);
        end
    end

    // Result register, loaded only by the SAMPLE capture strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_r   <= '0;
            overflow_r <= 1'b0;
        end else if (capture_s) begin
            result_r   <= cap_ovf_s ? FULL_SCALE : code_r;
            overflow_r <= cap_ovf_s;
        end
    end

    assign dac_code     = code_r;
    assign busy         = busy_r;
    assign result       = result_r;
    assign result_valid = valid_r;
    assign overflow     = overflow_r;

endmodule

// File: tb/tb_ramp_adc_sequencer.sv
// Self-checking bench for ramp_adc_sequencer (WIDTH=4, SETTLE_CYCLES=3, SYNC_STAGES=2).
module tb_ramp_adc_sequencer;

    localparam int W      = 4;
    localparam int SETTLE = 3;
    localparam int SYNC   = 2;
    localparam int STEP   = SETTLE + 1;
    localparam int FS     = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         comp_in;
    logic [W-1:0] dac_code;
    logic         busy;
    logic [W-1:0] result;
    logic         result_valid;
    logic         result_ready;
    logic         overflow;

    int           thr;
    logic         comp_mode;
    logic         comp_force;
    int           n_checks = 0;
    int           n_fail   = 0;

    // The analog input sits at threshold thr: the comparator trips once the ramp reaches it.
    assign comp_in = comp_mode ? comp_force : (int'(dac_code) >= thr);

    ramp_adc_sequencer #(
        .WIDTH        (W),
        .SETTLE_CYCLES(SETTLE),
        .SYNC_STAGES  (SYNC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .comp_in     (comp_in),
        .dac_code    (dac_code),
        .busy        (busy),
        .result      (result),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Start a conversion from IDLE against threshold t; checks ramp, latency and captured value.
    task automatic run_conv(input int t, input logic rdy, output int vcyc);
        int cyc;
        int k;
        thr          = t;
        comp_mode    = 1'b0;
        result_ready = rdy;
        start        = 1'b1;
        cyc          = 0;
        vcyc         = -1;
        while (vcyc < 0 && cyc < 200) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            start = 1'b0;
            if (result_valid) begin
                vcyc = cyc;
            end else begin
                chk("ramp_code", 32'(dac_code), 32'((cyc - 1) / STEP));
                chk("busy_ramp", 32'(busy), 32'd1);
            end
        end
        k = (t > FS) ? FS : t;
        chk("valid_cycle", 32'(vcyc), 32'((k + 1) * STEP + 1));
        chk("result", 32'(result), 32'(k));
        chk("overflow", 32'(overflow), (t > FS) ? 32'd1 : 32'd0);
    endtask

    // One cycle after an accepted handshake the block is idle with the result held.
    task automatic post_idle(input int k, input logic ovf);
        @(posedge clk);
        @(negedge clk);
        chk("idle_valid", 32'(result_valid), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_dac", 32'(dac_code), 32'd0);
        chk("idle_result", 32'(result), 32'(k));
        chk("idle_ovf", 32'(overflow), 32'(ovf));
    endtask

    initial begin
        int v;
        int t;
        int cyc;
        int nres;
        reset        = 1'b1;
        start        = 1'b0;
        result_ready = 1'b0;
        comp_mode    = 1'b0;
        comp_force   = 1'b0;
        thr          = 99;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_dac", 32'(dac_code), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(result_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        reset = 1'b0;
        @(negedge clk);

`ifdef RAMP_ADC_CONT_CONV_EN
        thr          = 2;
        comp_mode    = 1'b0;
        result_ready = 1'b1;
        start        = 1'b1;
        nres         = 0;
        for (cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            chk("cont_busy", 32'(busy), 32'd1);
            chk("cont_valid", 32'(result_valid), (cyc % 13 == 0) ? 32'd1 : 32'd0);
            if (result_valid) begin
                nres++;
                chk("cont_result", 32'(result), 32'd2);
            end
        end
        chk("cont_count", 32'(nres), 32'd3);
`else
        // Directed: trip at 5, never trip, trip immediately.
        run_conv(5, 1'b1, v);
        post_idle(5, 1'b0);
        run_conv(16, 1'b1, v);
        post_idle(FS, 1'b1);
        run_conv(0, 1'b1, v);
        post_idle(0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            t = int'($urandom_range(0, FS + 1));
            run_conv(t, 1'b1, v);
            post_idle((t > FS) ? FS : t, (t > FS) ? 1'b1 : 1'b0);
        end

        // Consumer stalls: DONE must hold steady while start and comparator toggle.
        run_conv(3, 1'b0, v);
        comp_mode = 1'b1;
        for (int i = 0; i < 10; i++) begin
            start      = 1'($urandom);
            comp_force = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            chk("stall_valid", 32'(result_valid), 32'd1);
            chk("stall_result", 32'(result), 32'd3);
            chk("stall_busy", 32'(busy), 32'd1);
            chk("stall_dac", 32'(dac_code), 32'd3);
        end
        result_ready = 1'b1;
        start        = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("hs_valid", 32'(result_valid), 32'd0);
        chk("hs_start_ignored", 32'(busy), 32'd0);
        start     = 1'b0;
        comp_mode = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("hs_still_idle", 32'(busy), 32'd0);
        chk("hs_result_kept", 32'(result), 32'd3);

        // Reset in cycle 12 of a ramp aborts everything.
        thr   = 5;
        start = 1'b1;
        for (cyc = 1; cyc <= 12; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
        end
        chk("pre_abort_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_dac", 32'(dac_code), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(result_valid), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        run_conv(7, 1'b1, v);
        post_idle(7, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ramp_adc_sequencer.md
Name: ramp_adc_sequencer

Overview:
Controller for the single-slope ramp ADC. It steps a DAC/PWM ramp code, waits a settle interval at each step, and samples the synchronized external comparator. On the first trip, or at full scale, it loads the code into the result register and presents the result over a valid/ready handshake. It sits between the ramp PWM generator (dac_code consumer) and the downstream sample consumer.

Parameters:
WIDTH, 8, ramp/result resolution in bits
SETTLE_CYCLES, 16, cycles dac_code is held before each comparator sample; must be >= SYNC_STAGES and >= 1
SYNC_STAGES, 2, comparator synchronizer flop count (>= 2)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  conversion request; sampled only in IDLE
comp_in  input  1  asynchronous comparator output; 1 = ramp >= analog input
dac_code  output  WIDTH  current ramp code to PWM/DAC
busy  output  1  high in SETTLE, SAMPLE and DONE
result  output  WIDTH  captured conversion code
result_valid  output  1  result available
result_ready  input  1  consumer accepts result
overflow  output  1  no trip by full scale; qualified by result_valid

Behaviour:
- Clock clk; reset is synchronous, active-high. Reset values: dac_code=0, result=0, result_valid=0, overflow=0, busy=0, state=IDLE, settle counter=0, synchronizer flops=0.
- comp_in passes through SYNC_STAGES flops to give comp_s. Only comp_s is used.
- States:
  - IDLE: dac_code=0. If start=1, set code=0 and settle counter=0, then go to SETTLE.
  - SETTLE: hold dac_code. Count 0..SETTLE_CYCLES-1, then go to SAMPLE.
  - SAMPLE (1 cycle):
    - If comp_s=1: result<=code, overflow<=0, go to DONE.
    - Else if code = 2^WIDTH-1: result<=all ones, overflow<=1, go to DONE.
    - Else: code<=code+1 with no wrap, counter cleared, go to SETTLE.
  - DONE: result_valid=1. result and overflow are held stable. On result_valid && result_ready, clear result_valid and go to IDLE (dac_code returns to 0).
- Timing: if start is accepted in cycle 0 and the trip occurs at code k, result_valid rises in cycle (k+1)*(SETTLE_CYCLES+1)+1.
- start while busy is ignored and not queued. start asserted in the same cycle as the DONE handshake is ignored; the new conversion begins once the block is back in IDLE.
- result_ready while result_valid=0 has no effect.
- result and overflow change only at capture in SAMPLE. They keep their value across IDLE until the next capture.
- Reset mid-conversion aborts immediately. All outputs return to reset values on the next clock; no partial result is retained.
- Code arithmetic is WIDTH-bit unsigned. The increment never executes at full scale.

Optional Feature:
Macro RAMP_ADC_CONT_CONV_EN.
- Defined: continuous mode. The DONE handshake goes directly to SETTLE with code=0, without passing through IDLE or needing start. busy stays high. start is still honoured from IDLE after reset.
- Undefined: single-shot behaviour as described above.

Decomposition:
- Package ramp_adc_pkg holds:
  - state enum typedef (IDLE, SETTLE, SAMPLE, DONE);
  - localparam helpers for full-scale code and settle-counter width ($clog2(SETTLE_CYCLES)).
- One sub-module: comp_sync, a parameterized SYNC_STAGES flop chain with synchronous reset.
- Result storage is an enable-loaded register driven by the SAMPLE capture strobe.

Test Plan:
All scenarios use WIDTH=4, SETTLE_CYCLES=3, SYNC_STAGES=2, unless stated.
- Model comp_in = (dac_code >= 5); pulse start in cycle 0 with result_ready=1 -> result_valid rises in cycle 25, result=5, overflow=0, back in IDLE in cycle 26.
- Hold comp_in=0 -> dac_code steps 0..15, result=15, overflow=1, result_valid rises in cycle 65.
- Hold comp_in=1 -> result=0, result_valid rises in cycle 5.
- Hold result_ready=0 for 10 cycles in DONE while toggling start and comp_in -> result and valid are stable, no new conversion starts; ready=1 -> one handshake, then IDLE.
- Assert reset in cycle 12 mid-ramp -> next cycle dac_code=0, busy=0, result_valid=0, result=0; a fresh start converts correctly.
- With RAMP_ADC_CONT_CONV_EN and comp_in = (dac_code >= 2), ready=1 -> back-to-back results of 2, with valid every 13 cycles and busy constantly high.
